// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_console_writer
// Description : Byte-stream front end for the tile text framebuffer. Accepts
//               characters over a valid/ready handshake, tracks a text cursor
//               and turns printable bytes and control codes into single-cell
//               framebuffer writes. Row clears (newline) and full-screen
//               clears (form feed, power-on) run as internal write sequences.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_data, i_valid  - incoming character byte and its qualifier
//               o_ready          - byte accepted at an edge with i_valid high
//               o_fb_addr/data/we- framebuffer write port (addr = x + HTILES*y)
//               o_cursor_x/y     - current cursor column / row
//               o_busy           - a clear sequence is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_writer #(
  parameter int         HTILES     = 80,
  parameter int         VTILES     = 60,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [ADDR_W-1:0]           o_fb_addr,
  output logic [7:0]                  o_fb_data,
  output logic                        o_fb_we,
  output logic [$clog2(HTILES)-1:0]   o_cursor_x,
  output logic [$clog2(VTILES)-1:0]   o_cursor_y,
  output logic                        o_busy
);

  localparam int c_x_w   = $clog2(HTILES);
  localparam int c_y_w   = $clog2(VTILES);
  localparam int c_cells = HTILES * VTILES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_cnt, w_cnt;
  logic [c_x_w-1:0]    r_x, w_x;
  logic [c_y_w-1:0]    r_y, w_y;
  logic [ADDR_W-1:0]   r_fb_addr, w_fb_addr;
  logic [7:0]          r_fb_data, w_fb_data;
  logic                r_fb_we, w_fb_we;
  logic                r_ready, r_busy;
  logic                w_ready;

  logic [ADDR_W-1:0]   w_row_base;
  logic [c_y_w-1:0]    w_y_next;

  // Row base uses the registered row; during CLR_ROW this is already the
  // row being cleared because the newline updates y on the accept edge.
  assign w_row_base = ADDR_W'(r_y) * ADDR_W'(HTILES);
  // Rows wrap to the top instead of scrolling.
  assign w_y_next   = (r_y == c_y_w'(VTILES - 1)) ? '0 : r_y + 1'b1;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_x       = r_x;
    w_y       = r_y;
    w_fb_we   = 1'b0;
    w_fb_addr = r_fb_addr;
    w_fb_data = r_fb_data;

    unique case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_data >= 8'h20 && i_data <= 8'h7E) begin
            w_fb_we   = 1'b1;
            w_fb_addr = w_row_base + ADDR_W'(r_x);
            w_fb_data = i_data;
            if (r_x != c_x_w'(HTILES - 1)) begin
              w_x = r_x + 1'b1;
            end else begin
              // Char stays on the old row; the new row is then cleared.
              w_x     = '0;
              w_y     = w_y_next;
              w_state = ST_CLR_ROW;
              w_cnt   = '0;
            end
          end else begin
            case (i_data)
              8'h0D: w_x = '0;
              8'h0A: begin
                w_x     = '0;
                w_y     = w_y_next;
                w_state = ST_CLR_ROW;
                w_cnt   = '0;
              end
              8'h08: begin
                if (r_x != '0) begin
                  w_x       = r_x - 1'b1;
                  w_fb_we   = 1'b1;
                  w_fb_addr = w_row_base + ADDR_W'(r_x - 1'b1);
                  w_fb_data = CLEAR_CHAR;
                end
              end
              8'h0C: begin
                w_x     = '0;
                w_y     = '0;
                w_state = ST_CLR_ALL;
                w_cnt   = '0;
              end
              default: ;  // consumed without effect
            endcase
          end
        end
      end

      ST_CLR_ROW: begin
        w_fb_we   = 1'b1;
        w_fb_addr = w_row_base + r_cnt;
        w_fb_data = CLEAR_CHAR;
        if (r_cnt == ADDR_W'(HTILES - 1)) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_CLR_ALL: begin
        w_fb_we   = 1'b1;
        w_fb_addr = r_cnt;
        w_fb_data = CLEAR_CHAR;
        if (r_cnt == ADDR_W'(c_cells - 1)) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover through a full clear.
        w_state = ST_CLR_ALL;
        w_cnt   = '0;
      end
    endcase
  end

  // Ready/busy are registered from the next state so they line up with it.
  assign w_ready = (w_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLR_ALL;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_x       <= w_x;
      r_y       <= w_y;
      r_fb_we   <= w_fb_we;
      r_fb_addr <= w_fb_addr;
      r_fb_data <= w_fb_data;
      r_ready   <= w_ready;
      r_busy    <= ~w_ready;
    end
  end

  assign o_ready    = r_ready;
  assign o_busy     = r_busy;
  assign o_fb_we    = r_fb_we;
  assign o_fb_addr  = r_fb_addr;
  assign o_fb_data  = r_fb_data;
  assign o_cursor_x = r_x;
  assign o_cursor_y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_text_console_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console_writer
// Description : Scoreboard bench for text_console_writer. Stimulus pushes the
//               expected framebuffer writes into a queue; a monitor pops and
//               compares on every cycle with o_fb_we high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_writer;

  localparam int H = 80;
  localparam int V = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [12:0] o_fb_addr;
  logic [7:0]  o_fb_data;
  logic        o_fb_we;
  logic [6:0]  o_cursor_x;
  logic [5:0]  o_cursor_y;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];
  int mx = 0;
  int my = 0;

  text_console_writer #(
    .HTILES(H), .VTILES(V), .ADDR_W(13), .CLEAR_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
    .o_fb_we(o_fb_we), .o_cursor_x(o_cursor_x), .o_cursor_y(o_cursor_y),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && o_fb_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h with empty queue", o_fb_addr, o_fb_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({o_fb_addr, o_fb_data} !== e) begin
          bad++;
          $display("FAIL fb_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   o_fb_addr, o_fb_data, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_w(input int addr, input logic [7:0] d);
    exp_q.push_back({13'(addr), d});
  endtask

  task automatic push_row(input int row);
    for (int c = 0; c < H; c++) push_w(row * H + c, 8'h20);
  endtask

  task automatic push_all();
    for (int a = 0; a < H * V; a++) push_w(a, 8'h20);
  endtask

  // Reference cursor model for the byte decoder.
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(my * H + mx, b);
      if (mx < H - 1) mx++;
      else begin mx = 0; my = (my == V - 1) ? 0 : my + 1; push_row(my); end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      mx = 0; my = (my == V - 1) ? 0 : my + 1; push_row(my);
    end else if (b == 8'h08) begin
      if (mx > 0) begin mx--; push_w(my * H + mx, 8'h20); end
    end else if (b == 8'h0C) begin
      mx = 0; my = 0; push_all();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    i_data  = b;
    i_valid = 1'b1;
    while (n < 10000) begin
      @(negedge clk);
      if (o_ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    model(b);
    send(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !o_ready) && n < 20000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},    int'(o_fb_we),    0);
    chk({tag, "_addr"},  int'(o_fb_addr),  0);
    chk({tag, "_data"},  int'(o_fb_data),  0);
    chk({tag, "_ready"}, int'(o_ready),    0);
    chk({tag, "_busy"},  int'(o_busy),     1);
    chk({tag, "_x"},     int'(o_cursor_x), 0);
    chk({tag, "_y"},     int'(o_cursor_y), 0);
  endtask

  // Counts cycles from a reset release (at a negedge) until o_ready is seen.
  task automatic cycles_to_ready(output int cyc);
    cyc = 0;
    while (cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (o_ready) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    #3;
    chk_reset("reset");
    repeat (2) @(posedge clk);

    // Power-on clear: 4800 writes, ready with the last one.
    push_all();
    @(negedge clk);
    rst = 1'b0;
    cycles_to_ready(cyc);
    chk("por_cycles", cyc, 4800);
    chk("por_busy", int'(o_busy), 0);
    #2;
    chk("por_queue_empty", exp_q.size(), 0);
    chk("por_x", int'(o_cursor_x), 0);
    chk("por_y", int'(o_cursor_y), 0);

    // "AB" from (0,0).
    put(8'h41);
    put(8'h42);
    drain();
    chk("ab_x", int'(o_cursor_x), 2);
    chk("ab_y", int'(o_cursor_y), 0);

    // CR back to column 0, then 81 printables wrap onto row 1.
    put(8'h0D);
    chk("cr_x", int'(o_cursor_x), 0);
    for (int i = 0; i < 81; i++) put(8'(8'h21 + (i % 64)));
    drain();
    chk("wrap81_x", int'(o_cursor_x), 1);
    chk("wrap81_y", int'(o_cursor_y), 1);

    // Walk down to row 59, then LF wraps to row 0 with an 80-cycle clear.
    while (my != V - 1) put(8'h0A);
    drain();
    chk("row59_y", int'(o_cursor_y), 59);
    model(8'h0A);
    send(8'h0A);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (o_ready) break;
      n++;
    end
    chk("lf_wrap_ready_low_cycles", n, 80);
    chk("lf_wrap_x", int'(o_cursor_x), 0);
    chk("lf_wrap_y", int'(o_cursor_y), 0);
    drain();

    // Backspace at (5,3) then at (0,3).
    put(8'h0A); put(8'h0A); put(8'h0A);
    for (int i = 0; i < 5; i++) put(8'(8'h61 + i));
    drain();
    chk("pre_bs_x", int'(o_cursor_x), 5);
    chk("pre_bs_y", int'(o_cursor_y), 3);
    chk("bs_model_addr", my * H + mx - 1, 244);
    put(8'h08);
    drain();
    chk("bs_x", int'(o_cursor_x), 4);
    chk("bs_y", int'(o_cursor_y), 3);
    put(8'h0D);
    put(8'h08);
    repeat (3) @(negedge clk);
    #2;
    chk("bs0_x", int'(o_cursor_x), 0);
    chk("bs0_y", int'(o_cursor_y), 3);
    drain();

    // Form feed clear aborted by reset around address 2000.
    send(8'h0C);
    mx = 0; my = 0;
    for (int a = 0; a < 2000; a++) push_w(a, 8'h20);
    repeat (2001) @(negedge clk);
    #2;
    chk("ff_partial_queue_empty", exp_q.size(), 0);
    chk("ff_busy_mid", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk_reset("midclr_reset");

    // Byte held on i_valid across the restarted clear: accepted once.
    i_data  = 8'h5A;
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    push_all();
    push_w(0, 8'h5A);
    rst = 1'b0;
    cycles_to_ready(cyc);
    chk("restart_cycles", cyc, 4800);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    mx = 1; my = 0;
    drain();
    repeat (4) @(negedge clk);
    chk("held_x", int'(o_cursor_x), 1);
    chk("held_y", int'(o_cursor_y), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the 80x60 tile text framebuffer that the VGA pixel pipeline reads. Accepts bytes over a valid/ready handshake, keeps a text cursor, and turns printable characters and control codes into single-cell writes on the framebuffer write port. Handles clear-screen and row-clear sequences internally. The framebuffer is addressed as `index_x + HTILES*index_y`, the same mapping the display side uses for reads.

## Interface
Parameters:
- `HTILES`, default 80: columns (HACTIVE/TILESIZE).
- `VTILES`, default 60: rows (VACTIVE/TILESIZE).
- `ADDR_W`, default 13: framebuffer address width, $clog2(HTILES*VTILES).
- `CLEAR_CHAR`, default 8'h20: code written to cleared cells.

Ports:
- `clk`, input, 1: system clock (framebuffer write side). One clock domain only.
- `rst`, input, 1: reset, asynchronous and active-high.
- `i_data`, input, 8: character byte.
- `i_valid`, input, 1: `i_data` valid.
- `o_ready`, output, 1: block can accept a byte this cycle.
- `o_fb_addr`, output, ADDR_W: framebuffer write address.
- `o_fb_data`, output, 8: framebuffer write data.
- `o_fb_we`, output, 1: framebuffer write strobe, one write per cycle high.
- `o_cursor_x`, output, $clog2(HTILES): cursor column.
- `o_cursor_y`, output, $clog2(VTILES): cursor row.
- `o_busy`, output, 1: a clear sequence is in progress.

## Operation
- FSM states:
  - IDLE: `o_ready`=1.
  - CLR_ROW: clears the row given by `o_cursor_y`.
  - CLR_ALL: clears all cells.
- `o_busy`=1 in CLR_ROW and CLR_ALL. `o_ready`=1 only in IDLE.
- A byte is accepted at a rising edge where `i_valid` && `o_ready`. Bytes not accepted are neither consumed nor dropped.
- Decoding of an accepted byte (x, y = cursor):
  - 0x20..0x7E: write byte at (x,y).
    - If x<HTILES-1: x+1.
    - Else: newline (see below).
  - 0x0D (CR): x=0. No write.
  - 0x0A (LF): newline. No write of the byte itself.
  - 0x08 (BS): if x>0, x-1 and write CLEAR_CHAR at the new (x,y). If x==0, no effect.
  - 0x0C (FF): x=0, y=0, go to CLR_ALL.
  - Any other code: ignored; counts as accepted.
- Newline: x=0. y = (y==VTILES-1) ? 0 : y+1. Go to CLR_ROW for the new y. Rows wrap to the top; there is no scrolling.
- CLR_ROW: writes CLEAR_CHAR to `y*HTILES+0 .. y*HTILES+HTILES-1` in ascending order, one per cycle, then returns to IDLE.
- CLR_ALL: writes CLEAR_CHAR to addresses `0 .. HTILES*VTILES-1` in ascending order, then returns to IDLE.
- Address arithmetic: `o_fb_addr = y*HTILES + x`, computed at ADDR_W bits with a constant multiply. Maximum address is 4799, which never exceeds ADDR_W.

## Timing
- Reset values (async assert): `o_fb_we`=0, `o_fb_addr`=0, `o_fb_data`=0, `o_ready`=0, `o_busy`=1, cursor=(0,0), state=CLR_ALL with clear counter 0.
- After reset, the power-on clear issues its first write (addr 0) at the first rising edge after `rst` falls.
- All outputs are registered.
- A printable byte accepted at edge N: `o_fb_we`/`o_fb_addr`/`o_fb_data` are valid for the cycle following edge N. The cursor updates at edge N.
- Clear sequence entered at edge N: clear writes are issued at edges N+1 .. N+K.
  - K = HTILES for CLR_ROW, K = HTILES*VTILES for CLR_ALL.
  - State returns to IDLE at edge N+K; the earliest next accept is edge N+K+1.
- Printable byte at x=HTILES-1: the char write is registered at edge N and the row clear follows at N+1..N+HTILES. The new row's cells are overwritten; the written char is on the old row and is kept.
- `o_fb_we`=0 in every cycle without a write (IDLE with no accept, or CR/LF/ignored/BS-at-0).
- `rst` asserted mid-sequence: aborts immediately. On release the block restarts CLR_ALL from address 0.
- `i_valid` held while `o_ready`=0: byte is held, not lost.

## Test plan
- Reset release → exactly 4800 writes of 0x20 to addresses 0..4799 on consecutive cycles; `o_busy` falls and `o_ready` rises after the last write; cursor (0,0).
- Send "AB" from (0,0) → writes (0,0x41) then (1,0x42), one cycle after each accept; cursor (2,0).
- 81 printable bytes from (0,0) → 80 writes to row 0, then 80 clears at addr 80..159, then char 81 written at addr 80; cursor (1,1).
- Cursor at row 59, send LF → cursor (0,0), clears at addr 0..79, `o_ready`=0 for exactly 80 cycles.
- BS at (5,3) → write 0x20 at addr 244, cursor (4,3). BS at (0,3) → no write, cursor unchanged.
- Assert `rst` during the FF clear at address ~2000 → outputs take their reset values asynchronously; after release the clear restarts at addr 0. Holding `i_valid` throughout clear → byte accepted exactly once, at the first IDLE edge.
